traffic_display: RTL and testbench

//  Consumer side of the traffic-light controller outputs (LAMPA/LAMPB, BCD ACOUNT/BCOUNT).

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_display_if.sv | 29 ++
 rtl/bcd_to_seg7.sv | 31 +++
 rtl/traffic_display.sv | 160 ++++++++++++++++
 tb/tb_traffic_display.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared constants and helpers for the traffic-light display block.
//   - Lamp codes as driven by the controller (one-hot).
//   - Bit positions inside FAULT_CODE.
//   - Special segment patterns (dash for a non-decimal nibble, blank).
//   - bcd_dec: one-step decrement of a 2-digit BCD count.
package traffic_pkg;

  localparam logic [3:0] LAMP_LEFT   = 4'd1;
  localparam logic [3:0] LAMP_GREEN  = 4'd2;
  localparam logic [3:0] LAMP_YELLOW = 4'd4;
  localparam logic [3:0] LAMP_RED    = 4'd8;

  localparam int FAULT_ILLEGAL  = 0;
  localparam int FAULT_CONFLICT = 1;
  localparam int FAULT_BCD      = 2;
  localparam int FAULT_STEP     = 3;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // {t,u} -> {t,u-1}, borrowing into the tens digit when the units are 0.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // A lamp code is legal only when exactly one of the four lamps is lit.
  function automatic logic lamp_legal(input logic [3:0] l);
    return (l == LAMP_LEFT) || (l == LAMP_GREEN) ||
           (l == LAMP_YELLOW) || (l == LAMP_RED);
  endfunction

endpackage

// File: rtl/traffic_display_if.sv
// traffic_display_if: controller outputs feeding the display block, plus the
// display/fault outputs it returns to the board.
//   EN          controller enable
//   LAMPA/LAMPB lamp codes (one-hot)
//   ACOUNT/BCOUNT 2-digit BCD countdowns {tens,units}
//   SEG/DIG     multiplexed 7-segment drive (registered)
//   FAULT/FAULT_CODE sticky protocol fault flags
// master = controller/board side, slave = traffic_display.
interface traffic_display_if;
  logic       EN;
  logic [3:0] LAMPA;
  logic [3:0] LAMPB;
  logic [7:0] ACOUNT;
  logic [7:0] BCOUNT;
  logic [6:0] SEG;
  logic [3:0] DIG;
  logic       FAULT;
  logic [3:0] FAULT_CODE;

  modport master (
    output EN, LAMPA, LAMPB, ACOUNT, BCOUNT,
    input  SEG, DIG, FAULT, FAULT_CODE
  );

  modport slave (
    input  EN, LAMPA, LAMPB, ACOUNT, BCOUNT,
    output SEG, DIG, FAULT, FAULT_CODE
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble to 7-segment glyph.
//   i_nib  in  4  digit value
//   o_seg  out 7  segments {g,f,e,d,c,b,a}, active-high
//   o_bad  out 1  high when i_nib > 9 (o_seg then shows a dash)
module bcd_to_seg7
  import traffic_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg,
  output logic       o_bad
);

  always_comb begin
    o_seg = SEG_DASH;
    o_bad = 1'b0;
    case (i_nib)
      4'd0: o_seg = 7'b0111111;
      4'd1: o_seg = 7'b0000110;
      4'd2: o_seg = 7'b1011011;
      4'd3: o_seg = 7'b1001111;
      4'd4: o_seg = 7'b1100110;
      4'd5: o_seg = 7'b1101101;
      4'd6: o_seg = 7'b1111101;
      4'd7: o_seg = 7'b0000111;
      4'd8: o_seg = 7'b1111111;
      4'd9: o_seg = 7'b1101111;
      default: o_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_display.sv
// traffic_display: scans the A/B BCD countdowns onto a 4-digit multiplexed
// 7-segment display and watches the controller outputs for protocol faults.
//   CLK   in   system clock
//   RST   in   asynchronous active-high reset
//   bus   slave modport of traffic_display_if (EN, lamps, counts in;
//         SEG, DIG, FAULT, FAULT_CODE out)
// Parameters: SCAN_DIV cycles per digit slot (>=2), BLANK_LZ blanks a zero
// tens digit, CONF_HOLD cycles without any red lamp before a conflict fault.
module traffic_display
  import traffic_pkg::*;
#(
  parameter int SCAN_DIV  = 16,
  parameter bit BLANK_LZ  = 1'b1,
  parameter int CONF_HOLD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  traffic_display_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(CONF_HOLD + 1);

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [6:0]      r_seg;
  logic [3:0]      r_dig;
  logic [3:0]      r_fault_code;
  logic [CW-1:0]   r_conf_cnt;
  logic [1:0][7:0] r_prev_cnt;
  logic [1:0][3:0] r_prev_lamp;
  logic            r_en_prev;

  logic            w_tick;
  logic [3:0]      w_nib;
  logic [6:0]      w_glyph;
  logic            w_bad;
  logic [6:0]      w_seg_next;
  logic [3:0]      w_dig_next;
  logic            w_illegal;
  logic            w_conf_cond;
  logic            w_conf_hit;
  logic [CW-1:0]   w_conf_cnt_next;
  logic [1:0][7:0] w_cnt;
  logic [1:0][3:0] w_lamp;
  logic [1:0]      w_step_bad;
  logic            w_step_fault;
  logic [3:0]      w_fault_set;

  assign w_cnt[0]  = bus.ACOUNT;
  assign w_cnt[1]  = bus.BCOUNT;
  assign w_lamp[0] = bus.LAMPA;
  assign w_lamp[1] = bus.LAMPB;

  // ---------------- scan ----------------
  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

  always_comb begin
    w_nib = bus.ACOUNT[3:0];
    case (r_idx)
      2'd0: w_nib = bus.ACOUNT[3:0];
      2'd1: w_nib = bus.ACOUNT[7:4];
      2'd2: w_nib = bus.BCOUNT[3:0];
      2'd3: w_nib = bus.BCOUNT[7:4];
      default: w_nib = bus.ACOUNT[3:0];
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_glyph),
    .o_bad (w_bad)
  );

  // Odd slots are tens digits; only those may be blanked when zero.
  always_comb begin
    w_seg_next = SEG_BLANK;
    w_dig_next = 4'b0000;
    if (bus.EN) begin
      w_dig_next = 4'b0001 << r_idx;
      if (BLANK_LZ && r_idx[0] && (w_nib == 4'd0)) begin
        w_seg_next = SEG_BLANK;
      end else begin
        w_seg_next = w_glyph;
      end
    end
  end

  // ---------------- monitors ----------------
  assign w_illegal   = bus.EN && (!lamp_legal(bus.LAMPA) || !lamp_legal(bus.LAMPB));
  assign w_conf_cond = bus.EN && (bus.LAMPA != LAMP_RED) && (bus.LAMPB != LAMP_RED);
  // The fault fires on the edge where the run length reaches CONF_HOLD.
  assign w_conf_hit  = w_conf_cond && (r_conf_cnt >= CW'(CONF_HOLD - 1));

  always_comb begin
    w_conf_cnt_next = '0;
    if (w_conf_cond) begin
      if (r_conf_cnt == CW'(CONF_HOLD)) begin
        w_conf_cnt_next = r_conf_cnt;
      end else begin
        w_conf_cnt_next = r_conf_cnt + 1'b1;
      end
    end
  end

  // A count change is legal when it is a one-step BCD decrement or when the
  // lamp of that direction changes in the same cycle (phase reload).
  for (genvar gi = 0; gi < 2; gi++) begin : g_step
    assign w_step_bad[gi] = (w_cnt[gi] != r_prev_cnt[gi]) &&
                            (w_lamp[gi] == r_prev_lamp[gi]) &&
                            !((r_prev_cnt[gi] != 8'h00) &&
                              (w_cnt[gi] == bcd_dec(r_prev_cnt[gi])));
  end

  // r_en_prev low means this is the first enabled cycle: history is stale.
  assign w_step_fault = bus.EN && r_en_prev && (|w_step_bad);

  always_comb begin
    w_fault_set                 = 4'b0000;
    w_fault_set[FAULT_ILLEGAL]  = w_illegal;
    w_fault_set[FAULT_CONFLICT] = w_conf_hit;
    w_fault_set[FAULT_BCD]      = bus.EN && w_bad;
    w_fault_set[FAULT_STEP]     = w_step_fault;
  end

  // ---------------- state ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_seg        <= SEG_BLANK;
      r_dig        <= 4'b0000;
      r_fault_code <= 4'b0000;
      r_conf_cnt   <= '0;
      r_prev_cnt   <= '0;
      r_prev_lamp  <= '0;
      r_en_prev    <= 1'b0;
    end else begin
      if (bus.EN) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_idx <= r_idx + 2'd1;
        end
      end
      r_seg        <= w_seg_next;
      r_dig        <= w_dig_next;
      r_fault_code <= r_fault_code | w_fault_set;
      r_conf_cnt   <= w_conf_cnt_next;
      r_prev_cnt   <= w_cnt;
      r_prev_lamp  <= w_lamp;
      r_en_prev    <= bus.EN;
    end
  end

  assign bus.SEG        = r_seg;
  assign bus.DIG        = r_dig;
  assign bus.FAULT_CODE = r_fault_code;
  assign bus.FAULT      = |r_fault_code;

endmodule

// File: tb/tb_traffic_display.sv
// Scoreboard bench for traffic_display: two instances (BLANK_LZ=1 and 0)
// share stimulus; a reference model pushes expected outputs per clock and a
// monitor pops and compares them after every rising edge.
module tb_traffic_display;
  import traffic_pkg::*;

  localparam int SD = 4;
  localparam int CH = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  traffic_display_if bus1 ();
  traffic_display_if bus0 ();

  traffic_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1), .CONF_HOLD(CH)) dut1 (
    .CLK (CLK), .RST (RST), .bus (bus1));
  traffic_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0), .CONF_HOLD(CH)) dut0 (
    .CLK (CLK), .RST (RST), .bus (bus0));

  typedef struct {
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic [3:0] dig;
    logic [3:0] fc;
    string      tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  string phase = "init";

  // stimulus
  logic       s_rst = 1'b1;
  logic       s_en  = 1'b0;
  logic [3:0] s_la  = 4'd8;
  logic [3:0] s_lb  = 4'd2;
  logic [7:0] s_ac  = 8'h40;
  logic [7:0] s_bc  = 8'h65;

  // reference model state
  int         m_n;        // enabled clock edges since reset
  bit         m_en_prev;
  logic [7:0] m_pa, m_pb;
  logic [3:0] m_pla, m_plb;
  int         m_run;      // consecutive cycles with no red lamp
  logic [3:0] m_fc;
  logic [6:0] gly [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic bit step_bad(input logic [7:0] c, input logic [7:0] p,
                                  input logic [3:0] l, input logic [3:0] pl);
    logic [7:0] d;
    if (c == p || l != pl) return 1'b0;
    if (p == 8'h00) return 1'b1;
    // a zero units digit borrows: t*16 - 7 == (t-1)*16 + 9
    d = (p[3:0] == 4'd0) ? p - 8'd7 : p - 8'd1;
    return c != d;
  endfunction

  task automatic model_edge();
    exp_t e;
    int idx;
    logic [3:0] nib;
    logic [3:0] f;
    e.tag = phase;
    f = 4'b0;
    if (RST) begin
      m_n = 0; m_en_prev = 0; m_pa = 0; m_pb = 0; m_pla = 0; m_plb = 0;
      m_run = 0; m_fc = 0;
      e.seg1 = 0; e.seg0 = 0; e.dig = 0; e.fc = 0;
    end else begin
      idx = (m_n / SD) % 4;
      case (idx)
        0: nib = s_ac[3:0];
        1: nib = s_ac[7:4];
        2: nib = s_bc[3:0];
        default: nib = s_bc[7:4];
      endcase
      e.dig = s_en ? 4'(1 << idx) : 4'b0;
      if (!s_en) begin
        e.seg1 = 0; e.seg0 = 0;
      end else if (nib > 9) begin
        e.seg1 = 7'b1000000; e.seg0 = 7'b1000000; f[2] = 1'b1;
      end else begin
        e.seg0 = gly[nib];
        e.seg1 = ((idx % 2 == 1) && nib == 0) ? 7'b0 : gly[nib];
      end
      if (s_en && ($countones(s_la) != 1 || $countones(s_lb) != 1)) f[0] = 1'b1;
      if (s_en && s_la != 4'd8 && s_lb != 4'd8) m_run++; else m_run = 0;
      if (m_run >= CH) f[1] = 1'b1;
      if (s_en && m_en_prev &&
          (step_bad(s_ac, m_pa, s_la, m_pla) || step_bad(s_bc, m_pb, s_lb, m_plb)))
        f[3] = 1'b1;
      m_fc = m_fc | f;
      m_pa = s_ac; m_pb = s_bc; m_pla = s_la; m_plb = s_lb; m_en_prev = s_en;
      if (s_en) m_n++;
      e.fc = m_fc;
    end
    q.push_back(e);
  endtask

  // One clock: drive at the falling edge, optionally pulse reset mid-cycle.
  task automatic cyc(input bit pulse);
    @(negedge CLK);
    RST = s_rst;
    bus1.EN = s_en; bus1.LAMPA = s_la; bus1.LAMPB = s_lb; bus1.ACOUNT = s_ac; bus1.BCOUNT = s_bc;
    bus0.EN = s_en; bus0.LAMPA = s_la; bus0.LAMPB = s_lb; bus0.ACOUNT = s_ac; bus0.BCOUNT = s_bc;
    if (pulse) begin
      #2 RST = 1'b1;
      #1;
      chk("async_rst_seg", {1'b0, bus1.SEG}, 8'h00);
      chk("async_rst_dig", {4'b0, bus1.DIG}, 8'h00);
      chk("async_rst_fault", {7'b0, bus1.FAULT}, 8'h00);
    end
    model_edge();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // Change counts with EN low for one cycle so the step monitor re-arms.
  task automatic reload(input logic [7:0] a, input logic [7:0] b);
    s_en = 1'b0; s_ac = a; s_bc = b;
    cyc(1'b0);
    s_en = 1'b1;
  endtask

  function automatic logic [7:0] rnd_bcd();
    logic [7:0] v;
    v[7:4] = 4'($urandom_range(0, 9));
    v[3:0] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [7:0] next_cnt(input logic [7:0] c);
    if (c[3:0] == 4'd0) return {c[7:4] - 4'd1, 4'd9};
    return {c[7:4], c[3:0] - 4'd1};
  endfunction

  function automatic logic [3:0] rnd_lamp();
    logic [3:0] l;
    l = 4'b0001 << $urandom_range(0, 3);
    return l;
  endfunction

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, "_seg_lz1"}, {1'b0, bus1.SEG}, {1'b0, e.seg1});
        chk({e.tag, "_seg_lz0"}, {1'b0, bus0.SEG}, {1'b0, e.seg0});
        chk({e.tag, "_dig"}, {4'b0, bus1.DIG}, {4'b0, e.dig});
        chk({e.tag, "_fcode"}, {4'b0, bus1.FAULT_CODE}, {4'b0, e.fc});
        chk({e.tag, "_fault"}, {7'b0, bus1.FAULT}, {7'b0, |e.fc});
        $display("cyc %s seg=%h dig=%b fc=%b", e.tag, bus1.SEG, bus1.DIG, bus1.FAULT_CODE);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    phase = "reset";
    s_rst = 1; hold(2);
    s_rst = 0; phase = "en_low"; hold(2);

    phase = "scan_4065"; s_en = 1; hold(20);

    phase = "blank_05"; reload(8'h05, 8'h65); hold(16);

    phase = "step_ok"; reload(8'h10, 8'h65); hold(3);
    s_ac = 8'h09; hold(3);
    s_ac = 8'h08; hold(3);

    phase = "step_bad"; reload(8'h10, 8'h65); hold(2);
    s_ac = 8'h08; hold(2);
    s_ac = 8'h07; hold(3);
    phase = "rst_pulse"; cyc(1'b1);
    s_en = 0; hold(1);

    phase = "conflict"; s_en = 1; s_la = 4'd8; s_lb = 4'd2; hold(2);
    s_la = 4'd2; hold(2);
    s_la = 4'd8; hold(1);
    s_la = 4'd2; hold(3);
    s_la = 4'd8; hold(2);
    phase = "rst_pulse"; cyc(1'b1);

    phase = "illegal"; s_la = 4'd8; s_lb = 4'd2; hold(2);
    s_la = 4'b0110; hold(1);
    s_la = 4'd8; hold(2);
    phase = "rst_pulse"; cyc(1'b1);

    phase = "bad_bcd"; reload(8'h3C, 8'h65); hold(8);
    phase = "rst_pulse"; cyc(1'b1);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) s_en = ~s_en;
      if ($urandom_range(0, 3) == 0) begin
        if (s_ac == 8'h00) begin s_ac = rnd_bcd(); s_la = rnd_lamp(); end
        else s_ac = next_cnt(s_ac);
      end
      if ($urandom_range(0, 3) == 0) begin
        if (s_bc == 8'h00) begin s_bc = rnd_bcd(); s_lb = rnd_lamp(); end
        else s_bc = next_cnt(s_bc);
      end
      if ($urandom_range(0, 59) == 0) s_ac = 8'($urandom);
      if ($urandom_range(0, 59) == 0) s_bc = 8'($urandom);
      if ($urandom_range(0, 19) == 0) s_la = rnd_lamp();
      if ($urandom_range(0, 19) == 0) s_lb = rnd_lamp();
      if ($urandom_range(0, 79) == 0) s_la = 4'($urandom);
      if ($urandom_range(0, 29) == 0) s_lb = 4'd8;
      cyc((i % 150) == 149);
    end

    hold(2);
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
